// File: rtl/vga_pixel_pipe.sv
// Pixel pipeline behind the VGA timing generator: frame-buffer fetch with 4x upscale or
// test-pattern substitution, RGB332->444 expansion, syncs re-aligned to a fixed 3-cycle latency.
module vga_pixel_pipe #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 400,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned ADDR_W     = 14,
    parameter int unsigned BAR_W      = 80
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              hSyncIn,
    input  logic              vSyncIn,
    input  logic [9:0]        pixelCnt,
    input  logic [8:0]        lineCnt,
    input  logic [1:0]        modeSel,
    input  logic [7:0]        solidColour,
    output logic [ADDR_W-1:0] fbAddr,
    input  logic [7:0]        fbData,
    output logic              hSyncOut,
    output logic              vSyncOut,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              frameStart
);

    localparam int unsigned PX_W   = 10;
    localparam int unsigned LN_W   = 9;
    localparam int unsigned SUM_W  = ADDR_W + 2;
    localparam int unsigned BAR_CW = $clog2(BAR_W);

    typedef enum logic [1:0] {
        MODE_FB    = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    mode_e mode_q, mode_d;
    logic  origin_c;

    // Source mode, latched only at the first pixel of a frame
    always_ff @(posedge clock) begin
        if (!reset) mode_q <= MODE_FB;
        else        mode_q <= mode_d;
    end

    always_comb begin
        mode_d = mode_q;
        if (origin_c) mode_d = mode_e'(modeSel);
    end

    assign origin_c = (pixelCnt == '0) && (lineCnt == '0);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BAR_CW-1:0] bar_sub_q, bar_sub_d, bar_sub_c;
    logic [2:0]        bar_idx_q, bar_idx_d, bar_idx_c;
    logic              act1_q, act1_d, act2_q, act2_d;
    logic              hs1_q, hs1_d, hs2_q, hs2_d, hs3_q, hs3_d;
    logic              vs1_q, vs1_d, vs2_q, vs2_d, vs3_q, vs3_d;
    logic              fs1_q, fs1_d, fs2_q, fs2_d, fs3_q, fs3_d;
    mode_e             mode1_q, mode1_d, mode2_q, mode2_d;
    logic [7:0]        pat1_q, pat1_d, pat2_q, pat2_d;
    logic [3:0]        red_q, red_d, green_q, green_d, blue_q, blue_d;

    logic              active_c;
    logic [LN_W-1:0]   cell_l;
    logic [PX_W-1:0]   cell_p;
    logic [SUM_W-1:0]  addr_sum;
    logic [2:0]        bar_col;
    logic [7:0]        bar_rgb, check_rgb, pix_c;

    always_comb begin
        active_c = (pixelCnt < PX_W'(H_ACTIVE)) && (lineCnt < LN_W'(V_ACTIVE));
        cell_l   = lineCnt >> SCALE_LOG2;
        cell_p   = pixelCnt >> SCALE_LOG2;
        // 160 cells per row: l*160 = l*128 + l*32
        addr_sum = (SUM_W'(cell_l) << 7) + (SUM_W'(cell_l) << 5) + SUM_W'(cell_p);
        addr_d   = active_c ? ADDR_W'(addr_sum) : addr_q;

        // Bar index tracks pixelCnt with a wrapping sub-counter instead of a divider
        bar_sub_c = (pixelCnt == '0) ? '0 : bar_sub_q;
        bar_idx_c = (pixelCnt == '0) ? '0 : bar_idx_q;
        bar_sub_d = bar_sub_c + BAR_CW'(1);
        bar_idx_d = bar_idx_c;
        if (bar_sub_c == BAR_CW'(BAR_W - 1)) begin
            bar_sub_d = '0;
            bar_idx_d = bar_idx_c + 3'd1;
        end
        bar_col   = 3'd7 - bar_idx_c;
        bar_rgb   = {{3{bar_col[2]}}, {3{bar_col[1]}}, {2{bar_col[0]}}};
        check_rgb = (pixelCnt[5] ^ lineCnt[5]) ? 8'hFF : 8'h00;

        pat1_d = 8'h00;
        case (mode_d)
            MODE_BARS:  pat1_d = bar_rgb;
            MODE_CHECK: pat1_d = check_rgb;
            MODE_SOLID: pat1_d = solidColour;
            default:    pat1_d = 8'h00;
        endcase

        act1_d  = active_c;
        hs1_d   = hSyncIn;
        vs1_d   = vSyncIn;
        fs1_d   = origin_c;
        mode1_d = mode_d;

        act2_d  = act1_q;
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;
        fs2_d   = fs1_q;
        mode2_d = mode1_q;
        pat2_d  = pat1_q;

        // fbData answers the address issued one stage earlier
        pix_c   = (mode2_q == MODE_FB) ? fbData : pat2_q;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (act2_q) begin
            red_d   = {pix_c[7:5], pix_c[7]};
            green_d = {pix_c[4:2], pix_c[4]};
            blue_d  = {pix_c[1:0], pix_c[1:0]};
        end
        hs3_d = hs2_q;
        vs3_d = vs2_q;
        fs3_d = fs2_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q    <= '0;
            bar_sub_q <= '0;
            bar_idx_q <= '0;
            act1_q    <= 1'b0;
            hs1_q     <= 1'b1;
            vs1_q     <= 1'b0;
            fs1_q     <= 1'b0;
            mode1_q   <= MODE_FB;
            pat1_q    <= '0;
            act2_q    <= 1'b0;
            hs2_q     <= 1'b1;
            vs2_q     <= 1'b0;
            fs2_q     <= 1'b0;
            mode2_q   <= MODE_FB;
            pat2_q    <= '0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            hs3_q     <= 1'b1;
            vs3_q     <= 1'b0;
            fs3_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            bar_sub_q <= bar_sub_d;
            bar_idx_q <= bar_idx_d;
            act1_q    <= act1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            fs1_q     <= fs1_d;
            mode1_q   <= mode1_d;
            pat1_q    <= pat1_d;
            act2_q    <= act2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            fs2_q     <= fs2_d;
            mode2_q   <= mode2_d;
            pat2_q    <= pat2_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            hs3_q     <= hs3_d;
            vs3_q     <= vs3_d;
            fs3_q     <= fs3_d;
        end
    end

    assign fbAddr     = addr_q;
    assign hSyncOut   = hs3_q;
    assign vSyncOut   = vs3_q;
    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign frameStart = fs3_q;

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// Scoreboard bench for vga_pixel_pipe: a driver pushes expected outputs tagged with the
// cycle they must appear in; a negedge monitor pops and compares.
module tb_vga_pixel_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        hSyncIn, vSyncIn;
    logic [9:0]  pixelCnt;
    logic [8:0]  lineCnt;
    logic [1:0]  modeSel;
    logic [7:0]  solidColour;
    logic [13:0] fbAddr;
    logic [7:0]  fbData;
    logic        hSyncOut, vSyncOut, frameStart;
    logic [3:0]  red, green, blue;

    always #5 clock = ~clock;

    vga_pixel_pipe dut (
        .clock(clock), .reset(reset), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
        .pixelCnt(pixelCnt), .lineCnt(lineCnt), .modeSel(modeSel),
        .solidColour(solidColour), .fbAddr(fbAddr), .fbData(fbData),
        .hSyncOut(hSyncOut), .vSyncOut(vSyncOut), .red(red), .green(green),
        .blue(blue), .frameStart(frameStart)
    );

    // Synchronous frame-buffer RAM, one-cycle read latency
    logic [7:0] mem [0:16383];
    initial for (int i = 0; i < 16384; i++) mem[i] = 8'(i);
    always @(posedge clock) fbData <= mem[fbAddr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         tgt;
        logic [3:0] r, g, b;
        logic       hs, vs, fs;
    } out_t;
    typedef struct {
        int          tgt;
        logic [13:0] a;
    } addr_t;

    out_t  out_q[$];
    addr_t addr_q[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    m_mode  = 0;
    int    m_addr  = 0;

    function automatic out_t blank(input int tgt);
        out_t e;
        e.tgt = tgt; e.r = 4'h0; e.g = 4'h0; e.b = 4'h0;
        e.hs = 1'b1; e.vs = 1'b0; e.fs = 1'b0;
        return e;
    endfunction

    // Reference model for one input cycle; outputs due 3 cycles later, address 1 cycle later
    task automatic step(input int px, input int ln, input int ms, input int sc,
                        input logic hs, input logic vs, input logic rst);
        out_t       e;
        addr_t      a;
        logic [7:0] c;
        logic [2:0] cv;
        bit         act;
        reset = rst; pixelCnt = 10'(px); lineCnt = 9'(ln); modeSel = 2'(ms);
        solidColour = 8'(sc); hSyncIn = hs; vSyncIn = vs;
        if (!rst) begin
            m_mode = 0;
            m_addr = 0;
            while (out_q.size() > 0 && out_q[$].tgt > cyc) void'(out_q.pop_back());
            for (int d = 1; d <= 3; d++) out_q.push_back(blank(cyc + d));
        end else begin
            if (px == 0 && ln == 0) m_mode = ms;
            act = (px < 640) && (ln < 400);
            c = 8'h00;
            if (act) begin
                m_addr = (ln / 4) * 160 + px / 4;
                case (m_mode)
                    0: c = mem[m_addr];
                    1: begin
                        cv = 3'(7 - px / 80);
                        c = {cv[2] ? 3'h7 : 3'h0, cv[1] ? 3'h7 : 3'h0, cv[0] ? 2'h3 : 2'h0};
                    end
                    2: c = (((px / 32) % 2) != ((ln / 32) % 2)) ? 8'hFF : 8'h00;
                    default: c = 8'(sc);
                endcase
            end
            e.tgt = cyc + 3;
            e.r  = act ? {c[7:5], c[7]} : 4'h0;
            e.g  = act ? {c[4:2], c[4]} : 4'h0;
            e.b  = act ? {c[1:0], c[1:0]} : 4'h0;
            e.hs = hs; e.vs = vs; e.fs = (px == 0 && ln == 0);
            out_q.push_back(e);
        end
        a.tgt = cyc + 1;
        a.a   = 14'(m_addr);
        addr_q.push_back(a);
        @(posedge clock);
        #1;
    endtask

    task automatic run_line(input int ln, input int p0, input int p1, input int ms,
                            input int sc, input int rst_px);
        for (int px = p0; px <= p1; px++)
            step(px, ln, ms, sc, !(px >= 656 && px < 752), (ln >= 412 && ln < 414),
                 px != rst_px);
    endtask

    out_t  mon_e;
    addr_t mon_a;

    always @(negedge clock) begin
        while (out_q.size() > 0 && out_q[0].tgt < cyc) begin
            mon_e = out_q.pop_front();
            n_total++;
            $display("FAIL out_missed tgt=%0d now=%0d", mon_e.tgt, cyc);
        end
        if (out_q.size() > 0 && out_q[0].tgt == cyc) begin
            mon_e = out_q.pop_front();
            n_total++;
            if (red === mon_e.r && green === mon_e.g && blue === mon_e.b &&
                hSyncOut === mon_e.hs && vSyncOut === mon_e.vs && frameStart === mon_e.fs)
                n_pass++;
            else
                $display("FAIL pixel_out cyc=%0d got rgb=%h%h%h hs=%b vs=%b fs=%b want rgb=%h%h%h hs=%b vs=%b fs=%b",
                         cyc, red, green, blue, hSyncOut, vSyncOut, frameStart,
                         mon_e.r, mon_e.g, mon_e.b, mon_e.hs, mon_e.vs, mon_e.fs);
        end
        while (addr_q.size() > 0 && addr_q[0].tgt < cyc) begin
            mon_a = addr_q.pop_front();
            n_total++;
            $display("FAIL addr_missed tgt=%0d now=%0d", mon_a.tgt, cyc);
        end
        if (addr_q.size() > 0 && addr_q[0].tgt == cyc) begin
            mon_a = addr_q.pop_front();
            n_total++;
            if (fbAddr === mon_a.a) n_pass++;
            else $display("FAIL fb_addr cyc=%0d got %0d want %0d", cyc, fbAddr, mon_a.a);
        end
    end

    initial begin
        int px, ln, ms;
        reset = 1'b0; hSyncIn = 1'b1; vSyncIn = 1'b0; pixelCnt = '0; lineCnt = '0;
        modeSel = '0; solidColour = '0;
        @(posedge clock);
        #1;
        // Reset held low with arbitrary inputs
        for (int i = 0; i < 5; i++)
            step($urandom_range(0, 799), $urandom_range(0, 448), $urandom_range(0, 3),
                 $urandom_range(0, 255), 1'($urandom), 1'($urandom), 1'b0);
        // Solid red at frame origin
        run_line(0, 0, 15, 3, 8'hE0, -1);
        // Frame buffer, line 5 pixel 13 -> address 163
        run_line(0, 0, 9, 0, 0, -1);
        run_line(5, 0, 20, 0, 0, -1);
        // Colour bars over full lines, includes hsync falling at 656
        run_line(0, 0, 799, 1, 0, -1);
        run_line(3, 0, 799, 1, 0, -1);
        // Mode request mid-frame only takes effect at the next origin
        run_line(0, 0, 9, 0, 0, -1);
        run_line(199, 0, 799, 0, 0, -1);
        run_line(200, 0, 799, 2, 0, -1);
        run_line(399, 0, 799, 2, 0, -1);
        run_line(412, 0, 799, 2, 0, -1);
        run_line(0, 0, 799, 2, 0, -1);
        run_line(40, 0, 799, 2, 0, -1);
        // Reset pulse mid-line
        run_line(100, 0, 799, 2, 0, 150);
        run_line(101, 0, 799, 2, 0, -1);
        // Random counters, modes, colours, syncs and occasional reset
        for (int i = 0; i < 3000; i++) begin
            px = $urandom_range(0, 799);
            ln = $urandom_range(0, 448);
            ms = $urandom_range(0, 3);
            if ($urandom_range(0, 49) == 0) begin
                px = 0;
                ln = 0;
            end
            if (px == 0 && ln == 0 && ms == 1) ms = 2;
            step(px, ln, ms, $urandom_range(0, 255), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 199) != 0);
        end
        repeat (5) @(posedge clock);
        #1;
        n_total++;
        if (out_q.size() == 0 && addr_q.size() == 0) n_pass++;
        else $display("FAIL drain pending out=%0d addr=%0d want 0", out_q.size(), addr_q.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
